// File: rtl/sipo_pkg.sv
// Shared constants and state encoding for the byte-to-block SIPO assembler.
package sipo_pkg;

  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 16;
  localparam int BLOCK_W   = BYTE_W * NUM_BYTES;
  localparam int CNT_W     = 5;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } sipo_state_t;

endpackage

// File: rtl/sipo_idle_timer.sv
// Idle counter for the SIPO assembler: counts enabled cycles and pulses tc_o
// on the cycle the count reaches TIMEOUT_CYCLES-1, then restarts from zero.
module sipo_idle_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign tc_o = en_i && (cnt_q == LAST);

  // Count while enabled; any disable (byte arrival, FULL, empty) restarts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!en_i || tc_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_block_assembler.sv
// Serial-in/parallel-out block assembler: collects NUM_BYTES bytes (first byte
// ends up in the top byte lane) and offers the block over valid/ready, with a
// sticky overrun flag for bytes dropped while a block is pending.
// Optional partial-block timeout is enabled by defining SIPO_TIMEOUT_EN.
module sipo_block_assembler
  import sipo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BYTE_W-1:0]  byte_in,
  input  logic               byte_valid,
  output logic [BLOCK_W-1:0] block_out,
  output logic               block_valid,
  input  logic               block_ready,
  output logic [CNT_W-1:0]   byte_count,
  output logic               overrun,
  input  logic               overrun_clr
);

  sipo_state_t        state_q, state_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overrun_q, overrun_d;
  logic [BLOCK_W-1:0] shifted;
  logic               timeout_tc;

  assign shifted = {block_q[BLOCK_W-BYTE_W-1:0], byte_in};

`ifdef SIPO_TIMEOUT_EN
  logic idle_en;

  // Idle only counts while a partial block is held and no byte arrives.
  assign idle_en = (state_q == COLLECT) && (count_q != '0) && !byte_valid;

  sipo_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk_i (clk),
    .rst_i (reset),
    .en_i  (idle_en),
    .tc_o  (timeout_tc)
  );
`else
  logic unused_timeout_cfg;

  assign timeout_tc         = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Next-state logic for the collect/full handshake, shift register and flags.
  always_comb begin
    state_d   = state_q;
    block_d   = block_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    // Clear first so a drop in the same cycle below wins.
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    case (state_q)
      COLLECT: begin
        if (byte_valid) begin
          block_d = shifted;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(NUM_BYTES - 1)) begin
            state_d = FULL;
          end
        end else if (timeout_tc) begin
          block_d = '0;
          count_d = '0;
        end
      end
      FULL: begin
        if (block_ready) begin
          state_d = COLLECT;
          if (byte_valid) begin
            block_d = shifted;
            count_d = CNT_W'(1);
          end else begin
            count_d = '0;
          end
        end else if (byte_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= COLLECT;
      block_q   <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      block_q   <= block_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign block_out   = block_q;
  assign block_valid = (state_q == FULL);
  assign byte_count  = count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sipo_block_assembler.sv
// Self-checking bench for sipo_block_assembler: directed stimulus pushes the
// expected block into a queue; a monitor compares on every block_valid rise.
module tb_sipo_block_assembler;
  import sipo_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [BYTE_W-1:0]  byte_in = '0;
  logic               byte_valid = 1'b0;
  logic [BLOCK_W-1:0] block_out;
  logic               block_valid;
  logic               block_ready = 1'b0;
  logic [CNT_W-1:0]   byte_count;
  logic               overrun;
  logic               overrun_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [BLOCK_W-1:0] exp_q[$];
  logic               prev_valid = 1'b0;

  always #5 clk = ~clk;

  sipo_block_assembler #(
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .byte_count  (byte_count),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  task automatic check(input string name, input logic [BLOCK_W-1:0] act,
                       input logic [BLOCK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each new block presented must match the queue head.
  always @(negedge clk) begin
    if (block_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor_block: got %h expected none queued", block_out);
      end else begin
        check("monitor_block", block_out, exp_q.pop_front());
        check("monitor_count", BLOCK_W'(byte_count), BLOCK_W'(NUM_BYTES));
      end
    end
    prev_valid <= block_valid;
  end

  task automatic send_byte(input logic [BYTE_W-1:0] b);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    block_ready = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [BLOCK_W-1:0] rt;
    logic [BLOCK_W-1:0] held;
    logic [BYTE_W-1:0]  sent [NUM_BYTES];
    logic [BYTE_W-1:0]  lane;

    // Reset state
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_block_out", block_out, '0);
    check("rst_valid", BLOCK_W'(block_valid), '0);
    check("rst_count", BLOCK_W'(byte_count), '0);
    check("rst_overrun", BLOCK_W'(overrun), '0);

    // Basic fill 0x01..0x10 with block_ready low
    exp_q.push_back(128'h0102030405060708090A0B0C0D0E0F10);
    for (int unsigned i = 1; i <= 16; i++) begin
      send_byte(BYTE_W'(i));
      if (i == 8) check("fill_count8", BLOCK_W'(byte_count), BLOCK_W'(8));
      if (i == 15) check("fill_not_valid15", BLOCK_W'(block_valid), '0);
    end
    check("fill_valid_latency", BLOCK_W'(block_valid), BLOCK_W'(1));
    check("fill_block", block_out, 128'h0102030405060708090A0B0C0D0E0F10);
    check("fill_count16", BLOCK_W'(byte_count), BLOCK_W'(16));

    // Overrun: drop while full
    send_byte(8'hAA);
    check("ovr_set", BLOCK_W'(overrun), BLOCK_W'(1));
    check("ovr_block_hold", block_out, 128'h0102030405060708090A0B0C0D0E0F10);
    check("ovr_count_hold", BLOCK_W'(byte_count), BLOCK_W'(16));
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr", BLOCK_W'(overrun), '0);
    @(negedge clk);
    overrun_clr = 1'b1;
    byte_in     = 8'hBB;
    byte_valid  = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    byte_valid  = 1'b0;
    check("ovr_set_beats_clr", BLOCK_W'(overrun), BLOCK_W'(1));
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr2", BLOCK_W'(overrun), '0);

    // Handshake alone releases the block; data goes stale but unchanged
    pulse_ready();
    check("hs_valid_low", BLOCK_W'(block_valid), '0);
    check("hs_count_zero", BLOCK_W'(byte_count), '0);
    check("hs_stale_block", block_out, 128'h0102030405060708090A0B0C0D0E0F10);

    // block_ready in COLLECT is ignored
    pulse_ready();
    check("collect_ready_ignored", BLOCK_W'(byte_count), '0);

    // Round trip, MSB byte first
    rt = 128'h0123456789ABCDEF_FEDCBA9876543210;
    exp_q.push_back(rt);
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      sent[i] = rt[BLOCK_W-1-8*i -: 8];
      send_byte(sent[i]);
    end
    check("rt_block", block_out, 128'h0123456789ABCDEF_FEDCBA9876543210);
    held = block_out;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      lane = held[BLOCK_W-1-8*i -: 8];
      check("rt_piso_byte", BLOCK_W'(lane), BLOCK_W'(sent[i]));
    end

    // Simultaneous ready + byte: byte becomes first of the next block
    @(negedge clk);
    block_ready = 1'b1;
    byte_valid  = 1'b1;
    byte_in     = 8'h5A;
    @(negedge clk);
    block_ready = 1'b0;
    byte_valid  = 1'b0;
    check("sim_count1", BLOCK_W'(byte_count), BLOCK_W'(1));
    check("sim_valid_low", BLOCK_W'(block_valid), '0);
    check("sim_low_byte", BLOCK_W'(block_out[7:0]), BLOCK_W'(8'h5A));
    check("sim_no_overrun", BLOCK_W'(overrun), '0);

    // Reset mid-block after 7 bytes
    for (int unsigned i = 0; i < 6; i++) send_byte(8'hC0 + BYTE_W'(i));
    check("mid_count7", BLOCK_W'(byte_count), BLOCK_W'(7));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_block", block_out, '0);
    check("mid_rst_count", BLOCK_W'(byte_count), '0);
    check("mid_rst_valid", BLOCK_W'(block_valid), '0);
    check("mid_rst_overrun", BLOCK_W'(overrun), '0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(128'h202122232425262728292A2B2C2D2E2F);
    for (int unsigned i = 0; i < NUM_BYTES; i++) send_byte(8'h20 + BYTE_W'(i));
    check("clean_block", block_out, 128'h202122232425262728292A2B2C2D2E2F);
    pulse_ready();
    check("clean_release", BLOCK_W'(byte_count), '0);

    // Partial-block idle behaviour
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    idle(20);
`ifdef SIPO_TIMEOUT_EN
    check("to_count_zero", BLOCK_W'(byte_count), '0);
    check("to_block_cleared", block_out, '0);
`else
    check("noto_count_hold", BLOCK_W'(byte_count), BLOCK_W'(3));
`endif
    send_byte(8'h44);
    idle(10);
    send_byte(8'h55);
    @(negedge clk);
`ifdef SIPO_TIMEOUT_EN
    check("gap_no_timeout", BLOCK_W'(byte_count), BLOCK_W'(2));
`else
    check("gap_count", BLOCK_W'(byte_count), BLOCK_W'(5));
`endif

    idle(2);
    check("scoreboard_empty", BLOCK_W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
